// File: rtl/mux8_rr_arbiter.sv
// Round-robin owner selection for an 8:1 mux: registered one-hot grant plus binary select index.
// Latency 1 cycle request-to-grant and release-to-handover; requesters are held off only by not owning gnt.
// HOLD_MAX bounds tenure under contention (0 = unlimited); no backpressure beyond the grant itself.
module mux8_rr_arbiter #(
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req_i,
    output logic [7:0] gnt_o,
    output logic [2:0] sel_o,
    output logic       busy_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

    state_t     state_q, state_d;
    logic [7:0] gnt_q, gnt_d;
    logic [2:0] sel_q, sel_d;
    logic       busy_q, busy_d;
    logic [7:0] hold_q, hold_d;

    logic [7:0] others;
    logic [7:0] cand;
    logic [2:0] winner;
    logic       hold_expired;

    // First set bit of mask scanning start, start+1, ... with 3-bit wrap.
    function automatic logic [2:0] rr_pick(input logic [7:0] mask, input logic [2:0] start);
        logic [2:0] idx;
        logic       found;
        rr_pick = start;
        found   = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idx = start + 3'(k);
            if (!found && mask[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    always_comb begin
        others       = req_i & ~(8'b1 << sel_q);
        cand         = (state_q == IDLE) ? req_i : others;
        winner       = rr_pick(cand, sel_q + 3'd1);
        hold_expired = (HOLD_MAX != 0) && (hold_q >= HOLD_LIM);
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                gnt_d = 8'h00;
                if (req_i != 8'h00) begin
                    gnt_d   = 8'b1 << winner;
                    sel_d   = winner;
                    hold_d  = 8'd1;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!req_i[sel_q] || (hold_expired && (others != 8'h00))) begin
                    if (others != 8'h00) begin
                        gnt_d  = 8'b1 << winner;
                        sel_d  = winner;
                        hold_d = 8'd1;
                    end else begin
                        gnt_d   = 8'h00;
                        hold_d  = 8'd0;
                        state_d = IDLE;
                    end
                end else if (hold_q != 8'hFF) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: begin
                gnt_d   = 8'h00;
                state_d = IDLE;
            end
        endcase
        busy_d = |gnt_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 8'h00;
            sel_q   <= 3'd7;
            busy_q  <= 1'b0;
            hold_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            hold_q  <= hold_d;
        end
    end

    assign gnt_o  = gnt_q;
    assign sel_o  = sel_q;
    assign busy_o = busy_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed checks of the round-robin mux arbiter with hold limits of 4 and 1.
module tb_mux8_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] req4, req1;
    logic [7:0] gnt4, gnt1;
    logic [2:0] sel4, sel1;
    logic       busy4, busy1;

    int total = 0;
    int bad   = 0;

    mux8_rr_arbiter #(.HOLD_MAX(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .req_i(req4),
        .gnt_o(gnt4), .sel_o(sel4), .busy_o(busy4)
    );

    mux8_rr_arbiter #(.HOLD_MAX(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_i(req1),
        .gnt_o(gnt1), .sel_o(sel1), .busy_o(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic inv_ok(input logic [7:0] g, input logic [2:0] s, input logic b);
        logic onehot0;
        onehot0 = ((g & (g - 8'd1)) == 8'h00);
        return onehot0 && (b == |g) && ((g == 8'h00) || g[s]);
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("inv4", 8'(inv_ok(gnt4, sel4, busy4)), 8'd1);
            chk("inv1", 8'(inv_ok(gnt1, sel1, busy1)), 8'd1);
        end
    end

    initial begin
        rst_n = 1'b1;
        req4  = 8'h00;
        req1  = 8'h00;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_gnt",  gnt4, 8'h00);
        chk("rst_busy", 8'(busy4), 8'h00);
        chk("rst_sel",  8'(sel4), 8'd7);
        step();
        step();
        rst_n = 1'b1;

        // rotation, HOLD_MAX=1, all requesting
        req1 = 8'hFF;
        for (int i = 0; i < 16; i++) begin
            step();
            chk("rot_sel", 8'(sel1), 8'(i % 8));
            chk("rot_gnt", gnt1, 8'h01 << (i % 8));
        end
        req1 = 8'h00;

        // single requester, never preempted
        req4 = 8'h20;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("single_gnt", gnt4, 8'h20);
        end
        chk("single_sel",  8'(sel4), 8'd5);
        chk("single_busy", 8'(busy4), 8'd1);
        req4 = 8'h00;
        step();
        chk("single_rel_gnt", gnt4, 8'h00);
        chk("single_rel_sel", 8'(sel4), 8'd5);

        // preemption after exactly 4 cycles
        req4 = 8'h04;
        step();
        chk("pre_gnt0", gnt4, 8'h04);
        req4 = 8'h24;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("pre_hold", gnt4, 8'h04);
        end
        step();
        chk("pre_switch", gnt4, 8'h20);
        chk("pre_sel",    8'(sel4), 8'd5);
        req4 = 8'h00;
        step();
        chk("pre_idle", gnt4, 8'h00);

        // back-to-back handover with wrap 6 -> 0
        req4 = 8'h40;
        step();
        chk("wrap_own6", gnt4, 8'h40);
        req4 = 8'h41;
        step();
        chk("wrap_keep6", gnt4, 8'h40);
        req4 = 8'h01;
        step();
        chk("wrap_gnt0", gnt4, 8'h01);
        chk("wrap_sel0", 8'(sel4), 8'd0);
        req4 = 8'h00;
        step();
        chk("wrap_idle", gnt4, 8'h00);

        // skip of non-requesters
        req4 = 8'h02;
        step();
        chk("skip_own1", gnt4, 8'h02);
        req4 = 8'h90;
        step();
        chk("skip_gnt4", gnt4, 8'h10);
        chk("skip_sel4", 8'(sel4), 8'd4);
        step();
        step();
        chk("skip_keep4", gnt4, 8'h10);
        req4 = 8'h80;
        step();
        chk("skip_gnt7", gnt4, 8'h80);
        chk("skip_sel7", 8'(sel4), 8'd7);
        req4 = 8'h00;
        step();
        chk("skip_idle", gnt4, 8'h00);

        // asynchronous reset mid-grant
        req4 = 8'h08;
        step();
        chk("mid_gnt", gnt4, 8'h08);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_gnt",  gnt4, 8'h00);
        chk("mid_rst_busy", 8'(busy4), 8'h00);
        chk("mid_rst_sel",  8'(sel4), 8'd7);
        req4 = 8'h01;
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_gnt", gnt4, 8'h01);
        chk("post_rst_sel", 8'(sel4), 8'd0);
        req4 = 8'h00;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
